gpio_input_conditioner: RTL and testbench

Conditions the raw board inputs (centre push-button and 16 slide switches) before they enter the sigma SoC. It sits between the board pins and the `irq_btn_i`/`gpio_bi` inputs of `sigma`. It synchronises each input into the core clock domain and debounces each channel with a shared tick prescaler. It also generates a one-cycle button interrupt pulse and a switch-change strobe.

---
 rtl/gpio_input_conditioner.sv | 114 +++++++++++
 tb/tb_gpio_input_conditioner.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/gpio_input_conditioner.sv
// Board input conditioner: 2-flop synchronisers, shared-tick debouncers, button irq and switch-change strobe.
// Build option GPIO_COND_IRQ_EDGE_EN: irq_btn_o pulses on debounced press; otherwise it is the registered button level.
module gpio_input_conditioner #(
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 10,
    parameter int SW_WIDTH     = 16
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                btn_i,
    input  logic [SW_WIDTH-1:0] sw_i,
    output logic                btn_o,
    output logic                irq_btn_o,
    output logic [SW_WIDTH-1:0] sw_o,
    output logic                sw_changed_o
);
    localparam int NCH = SW_WIDTH + 1;
    localparam int PW  = $clog2(TICK_DIV);
    localparam int CW  = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [NCH-1:0]      r_sync1;
    logic [NCH-1:0]      r_sync2;
    logic [NCH-1:0]      r_q;
    logic [CW-1:0]       r_cnt [NCH];
    logic [PW-1:0]       r_pre;
    logic                w_tick;
    logic [SW_WIDTH-1:0] r_sw_d;
    logic                r_sw_changed;
    logic                r_irq;

    assign w_tick = (r_pre == PRE_LAST);

    // channel 0 is the button, channels 1..SW_WIDTH are the switches
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {sw_i, btn_i};
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    // a channel that agrees with its output clears its count, even on a tick
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (r_sync2[i] == r_q[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_tick) begin
                    if (r_cnt[i] == CNT_LAST) begin
                        r_q[i]   <= r_sync2[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_sw_d       <= '0;
            r_sw_changed <= 1'b0;
        end else begin
            r_sw_d       <= r_q[NCH-1:1];
            r_sw_changed <= |(r_q[NCH-1:1] ^ r_sw_d);
        end
    end

`ifdef GPIO_COND_IRQ_EDGE_EN
    logic r_btn_d;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_btn_d <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_btn_d <= r_q[0];
            r_irq   <= r_q[0] & ~r_btn_d;
        end
    end
`else
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_q[0];
        end
    end
`endif

    assign btn_o        = r_q[0];
    assign sw_o         = r_q[NCH-1:1];
    assign irq_btn_o    = r_irq;
    assign sw_changed_o = r_sw_changed;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Scoreboard bench for gpio_input_conditioner (TICK_DIV=4, STABLE_TICKS=3): expected output
// changes with latency windows are queued at stimulus time and popped when the outputs move.
module tb_gpio_input_conditioner;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_TICKS = 3;
    localparam int SW_WIDTH     = 16;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        btn_i;
    logic [15:0] sw_i;
    logic        btn_o;
    logic        irq_btn_o;
    logic [15:0] sw_o;
    logic        sw_changed_o;

    typedef struct {
        logic [15:0] value;
        int          t0;
        int          lo;
        int          hi;
    } exp_t;

    exp_t sw_q[$];
    exp_t btn_q[$];

    int          n_checks     = 0;
    int          n_err        = 0;
    int          cyc          = 0;
    logic        rst_applied  = 1'b1;
    logic [15:0] prev_sw      = '0;
    logic        prev_btn     = 1'b0;
    int          sw_chg_cyc   = -100;
    int          btn_rise_cyc = -100;

    gpio_input_conditioner #(
        .TICK_DIV    (TICK_DIV),
        .STABLE_TICKS(STABLE_TICKS),
        .SW_WIDTH    (SW_WIDTH)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .btn_i       (btn_i),
        .sw_i        (sw_i),
        .btn_o       (btn_o),
        .irq_btn_o   (irq_btn_o),
        .sw_o        (sw_o),
        .sw_changed_o(sw_changed_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_applied <= !rstn_i;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp_v, cyc);
        end
    endtask

    task automatic push_sw(input logic [15:0] v, input int lo, input int hi);
        exp_t e;
        e.value = v;
        e.t0    = cyc;
        e.lo    = lo;
        e.hi    = hi;
        sw_q.push_back(e);
    endtask

    task automatic push_btn(input logic v, input int lo, input int hi);
        exp_t e;
        e.value = {15'd0, v};
        e.t0    = cyc;
        e.lo    = lo;
        e.hi    = hi;
        btn_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   lat;
        logic exp_irq;
        if (rst_applied) begin
            check("rst_btn_o", 32'(btn_o), 32'd0);
            check("rst_irq_btn_o", 32'(irq_btn_o), 32'd0);
            check("rst_sw_o", 32'(sw_o), 32'd0);
            check("rst_sw_changed_o", 32'(sw_changed_o), 32'd0);
            prev_sw      = '0;
            prev_btn     = 1'b0;
            sw_chg_cyc   = -100;
            btn_rise_cyc = -100;
        end else begin
`ifdef GPIO_COND_IRQ_EDGE_EN
            exp_irq = (cyc == btn_rise_cyc + 1);
`else
            exp_irq = prev_btn;
`endif
            check("irq_btn_o", 32'(irq_btn_o), 32'(exp_irq));
            check("sw_changed_o", 32'(sw_changed_o), 32'(cyc == sw_chg_cyc + 1));
            if (sw_o !== prev_sw) begin
                sw_chg_cyc = cyc;
                if (sw_q.size() == 0) begin
                    check("sw_unexpected_change", 32'(sw_o), 32'(prev_sw));
                end else begin
                    e   = sw_q.pop_front();
                    lat = cyc - e.t0;
                    check("sw_value", 32'(sw_o), 32'(e.value));
                    check("sw_latency_in_window", 32'(lat >= e.lo && lat <= e.hi), 32'd1);
                end
                prev_sw = sw_o;
            end
            if (btn_o !== prev_btn) begin
                if (btn_o) btn_rise_cyc = cyc;
                if (btn_q.size() == 0) begin
                    check("btn_unexpected_change", 32'(btn_o), 32'(prev_btn));
                end else begin
                    e   = btn_q.pop_front();
                    lat = cyc - e.t0;
                    check("btn_value", 32'(btn_o), 32'(e.value[0]));
                    check("btn_latency_in_window", 32'(lat >= e.lo && lat <= e.hi), 32'd1);
                end
            end
            prev_btn = btn_o;
        end
    end

    initial begin
        rstn_i = 1'b0;
        btn_i  = 1'b1;
        sw_i   = 16'hFFFF;
        repeat (5) @(negedge clk);

        // release with pins already high: prescaler starts at 0, so exactly 12 cycles
        rstn_i = 1'b1;
        push_btn(1'b1, 12, 12);
        push_sw(16'hFFFF, 12, 12);
        repeat (20) @(negedge clk);
        check("after_reset_sw_o", 32'(sw_o), 32'h0000FFFF);
        check("after_reset_btn_o", 32'(btn_o), 32'd1);

        btn_i = 1'b0;
        sw_i  = 16'h0000;
        push_btn(1'b0, 11, 14);
        push_sw(16'h0000, 11, 14);
        repeat (20) @(negedge clk);

        // clean press then release
        btn_i = 1'b1;
        push_btn(1'b1, 11, 14);
        repeat (20) @(negedge clk);
        check("press_btn_o", 32'(btn_o), 32'd1);
        btn_i = 1'b0;
        push_btn(1'b0, 11, 14);
        repeat (20) @(negedge clk);
        check("release_btn_o", 32'(btn_o), 32'd0);

        // bounce: 5-cycle pulses never span three ticks
        for (int k = 0; k < 12; k++) begin
            btn_i = (k % 2 == 0);
            repeat (5) @(negedge clk);
        end
        btn_i = 1'b0;
        repeat (20) @(negedge clk);
        check("bounce_btn_o", 32'(btn_o), 32'd0);

        // multi-bit switch change lands in one update
        sw_i = 16'h00A5;
        push_sw(16'h00A5, 11, 14);
        repeat (20) @(negedge clk);
        check("multi_sw_o", 32'(sw_o), 32'h000000A5);

        // reset after two ticks of sw[3] pending; debounce restarts from scratch
        sw_i = 16'h00AD;
        repeat (10) @(negedge clk);
        rstn_i = 1'b0;
        @(negedge clk);
        rstn_i = 1'b1;
        push_sw(16'h00AD, 12, 12);
        repeat (20) @(negedge clk);
        check("mid_reset_sw_o", 32'(sw_o), 32'h000000AD);

        check("sw_queue_drained", 32'(sw_q.size()), 32'd0);
        check("btn_queue_drained", 32'(btn_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
